// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: op codes, FSM states,
// memory write-enable polarity, the zero word, latched request payload and
// small op-classification helpers.
package mem_access_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    // Operation codes carried on req_op
    localparam logic [OP_W-1:0] MAU_OP_LW  = 3'd0;
    localparam logic [OP_W-1:0] MAU_OP_LB  = 3'd1;
    localparam logic [OP_W-1:0] MAU_OP_LBU = 3'd2;
    localparam logic [OP_W-1:0] MAU_OP_LH  = 3'd3;
    localparam logic [OP_W-1:0] MAU_OP_LHU = 3'd4;
    localparam logic [OP_W-1:0] MAU_OP_SW  = 3'd5;
    localparam logic [OP_W-1:0] MAU_OP_SB  = 3'd6;
    localparam logic [OP_W-1:0] MAU_OP_SH  = 3'd7;

    // Memory write-enable polarity
    localparam logic MEM_SAVE = 1'b1;
    localparam logic MEM_LOAD = 1'b0;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_ERR    = 3'd4,
        ST_RESP   = 3'd5
    } mau_state_e;

    // Request fields captured at accept
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [1:0]        lane;
        logic [DATA_W-1:0] wdata;
    } mau_req_t;

    function automatic logic op_is_store(input logic [OP_W-1:0] op);
        return (op == MAU_OP_SW) || (op == MAU_OP_SB) || (op == MAU_OP_SH);
    endfunction

    function automatic logic op_is_half(input logic [OP_W-1:0] op);
        return (op == MAU_OP_LH) || (op == MAU_OP_LHU) || (op == MAU_OP_SH);
    endfunction

    function automatic logic op_is_word(input logic [OP_W-1:0] op);
        return (op == MAU_OP_LW) || (op == MAU_OP_SW);
    endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// Combinational lane logic for the memory access unit.
// Ports:
//   word_i  - word read from memory
//   wdata_i - right-aligned store data
//   lane_i  - byte offset within the word (little-endian)
//   op_i    - operation code
//   ext_o   - extracted and extended load data (zero for stores)
//   merge_o - word with the addressed lane(s) replaced by store data
module mau_lane_merge
    import mem_access_unit_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        lane_i,
    input  logic [OP_W-1:0]   op_i,
    output logic [DATA_W-1:0] ext_o,
    output logic [DATA_W-1:0] merge_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Lane select
    always_comb begin
        byte_c = word_i[7:0];
        case (lane_i)
            2'd0:    byte_c = word_i[7:0];
            2'd1:    byte_c = word_i[15:8];
            2'd2:    byte_c = word_i[23:16];
            default: byte_c = word_i[31:24];
        endcase
        half_c = lane_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Load extension
    always_comb begin
        ext_o = ZERO_WORD;
        case (op_i)
            MAU_OP_LW:  ext_o = word_i;
            MAU_OP_LB:  ext_o = {{24{byte_c[7]}}, byte_c};
            MAU_OP_LBU: ext_o = {24'd0, byte_c};
            MAU_OP_LH:  ext_o = {{16{half_c[15]}}, half_c};
            MAU_OP_LHU: ext_o = {16'd0, half_c};
            default:    ext_o = ZERO_WORD;
        endcase
    end

    // Store lane insert
    always_comb begin
        merge_o = word_i;
        case (op_i)
            MAU_OP_SW: merge_o = wdata_i;
            MAU_OP_SB: begin
                case (lane_i)
                    2'd0:    merge_o[7:0]   = wdata_i[7:0];
                    2'd1:    merge_o[15:8]  = wdata_i[7:0];
                    2'd2:    merge_o[23:16] = wdata_i[7:0];
                    default: merge_o[31:24] = wdata_i[7:0];
                endcase
            end
            MAU_OP_SH: begin
                if (lane_i[1]) begin
                    merge_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_o[15:0] = wdata_i[15:0];
                end
            end
            default: merge_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: converts byte-addressed CPU loads/stores into word
// accesses on a word-addressed data memory. Sub-word stores run as a
// read-modify-write; misaligned or out-of-range requests never reach memory.
// Optional macro MAU_PERF_CNT_EN adds saturating load/store/error counters.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - request handshake (ready only when idle)
//   req_op/addr/wdata     - operation, byte address, right-aligned store data
//   resp_valid            - one-cycle completion pulse
//   resp_rdata/resp_err   - load result / error flag, held until next accept
//   dmem_wena/addr/wdata  - memory write enable, word address, write word
//   dmem_rdata            - combinational memory read word
//   cnt_load/store/err    - performance counters (MAU_PERF_CNT_EN only)
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              dmem_wena,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata
`ifdef MAU_PERF_CNT_EN
    ,
    output logic [15:0]       cnt_load,
    output logic [15:0]       cnt_store,
    output logic [15:0]       cnt_err
`endif
);

    mau_state_e        state_q;
    mau_req_t          req_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              dmem_wena_q;
    logic [ADDR_W-1:0] dmem_addr_q;
    logic [DATA_W-1:0] dmem_wdata_q;

    logic [31:0]       off_c;
    logic [ADDR_W-1:0] idx_c;
    logic              oor_c;
    logic              mis_c;
    logic              err_c;
    logic              accept_c;
    logic [DATA_W-1:0] ext_c;
    logic [DATA_W-1:0] merge_c;

    // Address decode of the incoming request; offset wraps modulo 2^32
    assign off_c    = req_addr - BASE_ADDR;
    assign idx_c    = off_c[ADDR_W+1:2];
    assign oor_c    = (off_c >> (ADDR_W + 2)) != 32'd0;
    assign mis_c    = (op_is_half(req_op) && off_c[0]) ||
                      (op_is_word(req_op) && (off_c[1:0] != 2'b00));
    assign err_c    = oor_c || mis_c;
    assign accept_c = req_valid && req_ready_q;

    // Memory read word is only consumed in LOAD and RMW_RD, both driven by req_q
    mau_lane_merge u_lane_merge (
        .word_i  (dmem_rdata),
        .wdata_i (req_q.wdata),
        .lane_i  (req_q.lane),
        .op_i    (req_q.op),
        .ext_o   (ext_c),
        .merge_o (merge_c)
    );

    // Control FSM with registered Moore outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= ZERO_WORD;
            dmem_wena_q  <= MEM_LOAD;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= ZERO_WORD;
        end else begin
            resp_valid_q <= 1'b0;
            dmem_wena_q  <= MEM_LOAD;
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        req_q.op     <= req_op;
                        req_q.lane   <= off_c[1:0];
                        req_q.wdata  <= req_wdata;
                        dmem_addr_q  <= idx_c;
                        resp_err_q   <= err_c;
                        resp_rdata_q <= ZERO_WORD;
                        req_ready_q  <= 1'b0;
                        if (err_c) begin
                            state_q <= ST_ERR;
                        end else if (req_op == MAU_OP_SW) begin
                            state_q      <= ST_WRITE;
                            dmem_wena_q  <= MEM_SAVE;
                            dmem_wdata_q <= req_wdata;
                        end else if (op_is_store(req_op)) begin
                            state_q <= ST_RMW_RD;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    resp_rdata_q <= ext_c;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RMW_RD: begin
                    dmem_wdata_q <= merge_c;
                    dmem_wena_q  <= MEM_SAVE;
                    state_q      <= ST_WRITE;
                end
                ST_WRITE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_ERR: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign dmem_wena  = dmem_wena_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;

`ifdef MAU_PERF_CNT_EN
    logic [15:0] cnt_load_q;
    logic [15:0] cnt_store_q;
    logic [15:0] cnt_err_q;

    // Saturating per-class completion counters; errors count only as errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_load_q  <= 16'd0;
            cnt_store_q <= 16'd0;
            cnt_err_q   <= 16'd0;
        end else if (state_q == ST_RESP) begin
            if (resp_err_q) begin
                if (cnt_err_q != 16'hFFFF) cnt_err_q <= cnt_err_q + 16'd1;
            end else if (op_is_store(req_q.op)) begin
                if (cnt_store_q != 16'hFFFF) cnt_store_q <= cnt_store_q + 16'd1;
            end else begin
                if (cnt_load_q != 16'hFFFF) cnt_load_q <= cnt_load_q + 16'd1;
            end
        end
    end

    assign cnt_load  = cnt_load_q;
    assign cnt_store = cnt_store_q;
    assign cnt_err   = cnt_err_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// traffic, checked every cycle against a transaction-level reference model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dmem_wena;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
`ifdef MAU_PERF_CNT_EN
    logic [15:0] cnt_load, cnt_store, cnt_err;
`endif

    mem_access_unit #(.ADDR_W(10), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dmem_wena  (dmem_wena),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
`ifdef MAU_PERF_CNT_EN
        .cnt_load   (cnt_load),
        .cnt_store  (cnt_store),
        .cnt_err    (cnt_err),
`endif
        .dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on the falling edge
    logic [31:0] mem [0:1023];
    assign dmem_rdata = mem[dmem_addr];
    always @(negedge clk) if (dmem_wena) mem[dmem_addr] <= dmem_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] ref_mem [0:1023];
    bit          m_busy = 0;
    int          m_cyc, m_lat, m_wr_cyc, m_rd_cyc;
    int          m_idx;
    logic [31:0] m_word, m_rdata;
    logic        m_err;
    int          n_acc = 0;

    task automatic model_accept();
        logic [31:0] off, w, sh, v, mask;
        int          lane;
        bit          half, word, store;
        off   = req_addr - BASE;
        lane  = int'(off % 4);
        m_idx = int'((off / 4) % 1024);
        half  = (req_op == MAU_OP_LH) || (req_op == MAU_OP_LHU) || (req_op == MAU_OP_SH);
        word  = (req_op == MAU_OP_LW) || (req_op == MAU_OP_SW);
        store = (req_op >= MAU_OP_SW);
        m_err = (off >= 32'd4096) || (half && (lane % 2 == 1)) || (word && lane != 0);
        m_rdata = 32'd0; m_wr_cyc = 0; m_rd_cyc = 0; m_lat = 2;
        if (!m_err) begin
            w  = ref_mem[m_idx];
            sh = w >> (8 * lane);
            if (!store) begin
                m_rd_cyc = 1;
                case (req_op)
                    MAU_OP_LW:  v = w;
                    MAU_OP_LB:  begin v = sh & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
                    MAU_OP_LBU: v = sh & 32'hFF;
                    MAU_OP_LH:  begin v = sh & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
                    default:    v = sh & 32'hFFFF;
                endcase
                m_rdata = v;
            end else if (req_op == MAU_OP_SW) begin
                m_wr_cyc = 1;
                m_word   = req_wdata;
            end else begin
                m_rd_cyc = 1; m_wr_cyc = 2; m_lat = 3;
                mask   = ((req_op == MAU_OP_SB) ? 32'hFF : 32'hFFFF) << (8 * lane);
                m_word = (w & ~mask) | ((req_wdata << (8 * lane)) & mask);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            m_cyc  = 0;
        end else if (m_busy) begin
            if (m_cyc == m_lat) begin
                m_busy = 0;
            end else begin
                if (m_wr_cyc != 0 && m_cyc == m_wr_cyc) ref_mem[m_idx] = m_word;
                m_cyc++;
            end
        end else if (req_valid) begin
            model_accept();
            n_acc++;
            m_busy = 1;
            m_cyc  = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    int          n_resp = 0;
    int          n_wena = 0;
    logic [31:0] last_rdata;
    logic        last_err;
    bit          prev_valid = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            bit ev, ew;
            ev = m_busy && (m_cyc == m_lat);
            ew = m_busy && (m_wr_cyc != 0) && (m_cyc == m_wr_cyc);
            check("req_ready", 32'(req_ready), 32'(!m_busy));
            check("resp_valid", 32'(resp_valid), 32'(ev));
            check("dmem_wena", 32'(dmem_wena), 32'(ew));
            if (ew) begin
                check("wr_addr", 32'(dmem_addr), 32'(m_idx));
                check("wr_data", dmem_wdata, m_word);
            end
            if (m_busy && m_rd_cyc != 0 && m_cyc == m_rd_cyc && !m_err)
                check("rd_addr", 32'(dmem_addr), 32'(m_idx));
            if (ev) begin
                check("resp_err", 32'(resp_err), 32'(m_err));
                check("resp_rdata", resp_rdata, m_rdata);
            end
            if (resp_valid) begin
                check("resp_pulse", 32'(prev_valid), 32'd0);
                n_resp++;
                last_rdata = resp_rdata;
                last_err   = resp_err;
            end
            if (dmem_wena) n_wena++;
            prev_valid = resp_valid;
        end else begin
            prev_valid = 0;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (m_busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat);
        wait_idle();
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, w0, a0, r0;
        logic [31:0] saved;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_dmem_wena", 32'(dmem_wena), 32'd0);
        check("rst_dmem_addr", 32'(dmem_addr), 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SW then LW at word 1
        w0 = n_wena;
        issue(MAU_OP_SW, 32'h1001_0004, 32'hDEAD_BEEF, lat);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_mem", mem[1], 32'hDEAD_BEEF);
        check("sw_model_mem", ref_mem[1], 32'hDEAD_BEEF);
        check("sw_wena_cycles", 32'(n_wena - w0), 32'd1);
        issue(MAU_OP_LW, 32'h1001_0004, 32'd0, lat);
        check("lw_lat", 32'(lat), 32'd2);
        check("lw_rdata", last_rdata, 32'hDEAD_BEEF);
        check("lw_err", 32'(last_err), 32'd0);

        // SB into lane 2, then signed / unsigned byte loads
        w0 = n_wena;
        issue(MAU_OP_SB, 32'h1001_0006, 32'h0000_0080, lat);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_wena_cycles", 32'(n_wena - w0), 32'd1);
        check("sb_mem", mem[1], 32'hDE80_BEEF);
        check("sb_model_mem", ref_mem[1], 32'hDE80_BEEF);
        issue(MAU_OP_LB, 32'h1001_0006, 32'd0, lat);
        check("lb_rdata", last_rdata, 32'hFFFF_FF80);
        issue(MAU_OP_LBU, 32'h1001_0006, 32'd0, lat);
        check("lbu_rdata", last_rdata, 32'h0000_0080);
        issue(MAU_OP_LH, 32'h1001_0006, 32'd0, lat);
        check("lh_rdata", last_rdata, 32'hFFFF_DE80);

        // Misaligned and out-of-range requests
        w0 = n_wena;
        issue(MAU_OP_LH, 32'h1001_0003, 32'd0, lat);
        check("mis_lat", 32'(lat), 32'd2);
        check("mis_err", 32'(last_err), 32'd1);
        check("mis_rdata", last_rdata, 32'd0);
        issue(MAU_OP_SW, 32'h1001_1000, 32'h1234_5678, lat);
        check("oor_err", 32'(last_err), 32'd1);
        check("oor_rdata", last_rdata, 32'd0);
        check("err_no_wena", 32'(n_wena - w0), 32'd0);

        // Reset during the RMW read cycle of an SH
        wait_idle();
        saved = mem[5];
        r0 = n_resp;
        req_valid = 1'b1; req_op = MAU_OP_SH; req_addr = BASE + 32'd22; req_wdata = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstmid_wena", 32'(dmem_wena), 32'd0);
        @(posedge clk); #1;
        check("rstmid_wena2", 32'(dmem_wena), 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstmid_ready", 32'(req_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("rstmid_mem", mem[5], saved);
        check("rstmid_no_resp", 32'(n_resp - r0), 32'd0);

        // Continuous req_valid with alternating LW/SW
        a0 = n_acc; r0 = n_resp;
        req_valid = 1'b1; req_addr = BASE + 32'd8;
        for (int c = 0; c < 40; c++) begin
            req_op    = (n_acc % 2 == 1) ? MAU_OP_SW : MAU_OP_LW;
            req_wdata = $urandom;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        wait_idle();
        check("stream_acc_eq_resp", 32'(n_resp - r0), 32'(n_acc - a0));
        check("stream_acc_enough", 32'((n_acc - a0) >= 13), 32'd1);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            int sel, lane;
            sel  = $urandom_range(0, 9);
            lane = $urandom_range(0, 3);
            req_op    = 3'($urandom_range(0, 7));
            req_wdata = $urandom;
            case (sel)
                0:       req_addr = $urandom;
                1:       req_addr = BASE + 32'hFFC + 32'(lane);
                2:       req_addr = BASE - 32'd4 + 32'(lane);
                3:       req_addr = BASE + 32'h1000 + 32'(lane);
                default: req_addr = BASE + 32'($urandom_range(0, 15) * 4 + lane);
            endcase
            req_valid = m_busy ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== ref_mem[i]) check("final_mem", mem[i], ref_mem[i]);
        check("final_mem_1023", mem[1023], ref_mem[1023]);

`ifdef MAU_PERF_CNT_EN
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("cnt_rst", 32'(cnt_load), 32'd0);
        for (int i = 0; i < 3; i++) issue(MAU_OP_LW, BASE + 32'(4 * i), 32'd0, lat);
        issue(MAU_OP_SW, BASE + 32'd16, 32'h1111_2222, lat);
        issue(MAU_OP_SB, BASE + 32'd17, 32'h33, lat);
        issue(MAU_OP_LW, BASE + 32'd2, 32'd0, lat);
        check("cnt_load", 32'(cnt_load), 32'd3);
        check("cnt_store", 32'(cnt_store), 32'd2);
        check("cnt_err", 32'(cnt_err), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly upstream of the word-addressed data memory.
- Takes byte-addressed load/store requests from the CPU datapath and converts them to word accesses.
- Sub-word loads (LB/LBU/LH/LHU) get lane extract plus sign/zero extension.
- Sub-word stores (SB/SH) run as a two-cycle read-modify-write, because the memory only writes whole words.
- Detects misaligned and out-of-range addresses; these never touch memory.

Parameters:
- ADDR_W, 10: word-address width driven to memory (1024 words).
- BASE_ADDR, 32'h1001_0000: byte address that maps to memory word 0.

Ports:
- clk  in  1  system clock, rising-edge logic.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, can accept a request.
- req_op  in  3  operation code; encodings in shared defines.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned or out-of-range.
- dmem_wena  out  1  1 = save, 0 = load (memory write-enable polarity).
- dmem_addr  out  ADDR_W  word address to memory.
- dmem_wdata  out  32  word to store.
- dmem_rdata  in  32  combinational read word from memory.

Behaviour:
- Op codes: LW=0, LB=1, LBU=2, LH=3, LHU=4, SW=5, SB=6, SH=7.
- Little-endian lanes: byte offset 0 maps to bits [7:0].
- Address math:
  - off = req_addr - BASE_ADDR, 32-bit, wraps.
  - Word index = off[ADDR_W+1:2].
  - Out of range if off[31:ADDR_W+2] != 0.
  - Misaligned if halfword op and off[0] = 1, or word op and off[1:0] != 0.
- Reset state: IDLE. Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dmem_wena=0, dmem_addr=0, dmem_wdata=0.
- Request latch: on the rising edge where req_valid && req_ready, latch op, index, offset, wdata and error flags.
- Only IDLE asserts req_ready. There is no queueing.
- FSM states, all Moore outputs:
  - IDLE: req_ready=1. Accept moves to ERR if err; LOAD for load ops; WRITE for SW; RMW_RD for SB/SH.
  - LOAD: dmem_wena=0, dmem_addr=index. At the edge, resp_rdata <= extract(dmem_rdata, off, op). Go to RESP.
  - RMW_RD: dmem_wena=0, dmem_addr=index. At the edge, merge reg <= dmem_rdata with the addressed lane(s) replaced by wdata. Go to WRITE.
  - WRITE: dmem_wena=1, dmem_addr=index, dmem_wdata = merge reg (SB/SH) or wdata (SW). Memory commits on the falling edge inside this cycle. Go to RESP.
  - ERR: resp_err is set, resp_rdata=0, dmem_wena=0. Go to RESP.
  - RESP: resp_valid=1 for exactly one cycle. Go to IDLE.
- Latency, from the accept edge to the resp_valid cycle:
  - Loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Errors: 2 cycles.
  - Back-to-back requests are accepted every 3 cycles (4 for SB/SH).
- Extension rules:
  - LB/LH: sign-extend from bit 7/15 of the lane.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- dmem_wena is high only in WRITE. Store ops never drive resp_rdata non-zero.
- resp_err and resp_rdata are held until the next accept; resp_valid qualifies them.
- Reset mid-operation: asynchronous return to IDLE, dmem_wena drops immediately.
  - If rst_n falls before the falling edge of a WRITE cycle, no write occurs.
  - A partial RMW never writes.
- req_valid held during a busy state is ignored until IDLE.

Optional Feature:
- Macro: MAU_PERF_CNT_EN.
- When defined:
  - Adds outputs cnt_load, cnt_store, cnt_err (16 bits each).
  - Counters increment on the RESP cycle of the matching class (errored requests count only as err).
  - Counters saturate at 16'hFFFF and reset to 0.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared defines header holds:
  - Op-code constants (MAU_OP_*).
  - State encodings.
  - Memory save/load polarity values.
  - The zero-word constant.
- Sub-module mau_lane_merge (combinational):
  - extract(word, off, op) gives the extended load data.
  - insert(word, wdata, off, op) gives the merged store word.
- The FSM and registers stay in mem_access_unit.

Test Plan:
- SW 0xDEADBEEF at 0x10010004, then LW at 0x10010004 -> dmem index 1 written in the WRITE cycle; LW resp_rdata=0xDEADBEEF 2 cycles after accept; resp_err=0.
- SB 0x80 at 0x10010006 over the stored word, then LB and LBU same address -> stored word 0xDE80BEEF; LB=0xFFFFFF80; LBU=0x00000080; SB takes 3 cycles, with dmem_wena high exactly 1 cycle.
- LH at 0x10010003 and SW at 0x10011000 -> both give resp_err=1, resp_rdata=0; dmem_wena never asserts.
- Assert rst_n low during the RMW_RD cycle of an SH -> dmem_wena stays 0; memory word unchanged; req_ready=1 after release; no resp_valid.
- Hold req_valid high continuously with an alternating LW/SW stream -> exactly one accept per completed response; resp_valid is a single-cycle pulse each time.
- With MAU_PERF_CNT_EN: 3 loads, 2 stores, 1 misaligned -> cnt_load=3, cnt_store=2, cnt_err=1.
